// File: rtl/vector_chunk_store.sv
// Ping-pong chunk memory: the shadow bank is written while the active bank is read; swap promotes a complete shadow.
// Optional VEC_STORE_ERR_EN adds sticky err_flags[3:0] for dropped or illegal requests.
module vector_chunk_store #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int depth_chunks  = 64,
    parameter int chunk_aw      = 6
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic [31:0]                          total,
    input  logic                                 wr_en,
    input  logic [element_width*no_of_units-1:0] wr_data,
    input  logic                                 rd_req,
    input  logic                                 rd_rewind,
    input  logic                                 swap,
    output logic [element_width*no_of_units-1:0] rd_data,
    output logic                                 rd_valid,
    output logic                                 rd_done,
    output logic                                 wr_done,
    output logic                                 wr_full,
    output logic                                 active_bank
`ifdef VEC_STORE_ERR_EN
    ,
    output logic [3:0]                           err_flags
`endif
);

    localparam int DW = element_width * no_of_units;
    localparam int CW = chunk_aw + 1;

    logic [DW-1:0] mem [0:2*depth_chunks-1];

    logic [31:0]   total_q;
    logic [31:0]   total_div;
    logic [CW-1:0] n_chunks;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] rd_count;
    logic          swap_ok;
    logic          wr_ok;
    logic          rd_ok;
    logic [CW-1:0] wr_addr;
    logic [CW-1:0] rd_addr;

    assign total_div = total_q / 32'(no_of_units);
    assign n_chunks  = (total_div > 32'(depth_chunks)) ? CW'(depth_chunks) : total_div[CW-1:0];

    // Swap needs wr_full already set, so an accepted swap can never coincide with an accepted write.
    assign swap_ok = swap && wr_full && !clear;
    assign wr_ok   = wr_en && !clear && !wr_full && (wr_count < n_chunks);
    assign rd_ok   = rd_req && !clear && !swap_ok && !rd_rewind && (rd_count < n_chunks);

    assign wr_addr = {~active_bank, wr_count[chunk_aw-1:0]};
    assign rd_addr = {active_bank, rd_count[chunk_aw-1:0]};

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q     <= '0;
            wr_count    <= '0;
            rd_count    <= '0;
            wr_full     <= 1'b0;
            wr_done     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_done     <= 1'b0;
            rd_data     <= '0;
            active_bank <= 1'b0;
        end else begin
            wr_done  <= 1'b0;
            rd_valid <= 1'b0;
            rd_done  <= 1'b0;
            if (rd_ok) begin
                rd_data  <= mem[rd_addr];
                rd_valid <= 1'b1;
                rd_done  <= (rd_count + CW'(1)) == n_chunks;
            end
            if (clear) begin
                total_q  <= total;
                wr_count <= '0;
                rd_count <= '0;
                wr_full  <= 1'b0;
            end else if (swap_ok) begin
                active_bank <= ~active_bank;
                wr_count    <= '0;
                rd_count    <= '0;
                wr_full     <= 1'b0;
            end else begin
                if (rd_rewind) begin
                    rd_count <= '0;
                end else if (rd_ok) begin
                    rd_count <= rd_count + CW'(1);
                end
                if (wr_ok) begin
                    wr_count <= wr_count + CW'(1);
                    if ((wr_count + CW'(1)) == n_chunks) begin
                        wr_full <= 1'b1;
                        wr_done <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef VEC_STORE_ERR_EN
    logic total_bad;
    assign total_bad = ((total % 32'(no_of_units)) != 32'd0) ||
                       ((total / 32'(no_of_units)) > 32'(depth_chunks));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_flags <= '0;
        end else if (clear) begin
            err_flags <= {total_bad, 3'b000};
        end else begin
            if (wr_en && !wr_ok) begin
                err_flags[0] <= 1'b1;
            end
            if (rd_req && !swap_ok && !rd_rewind && !(rd_count < n_chunks)) begin
                err_flags[1] <= 1'b1;
            end
            if (swap && !wr_full) begin
                err_flags[2] <= 1'b1;
            end
        end
    end
`endif

endmodule
